// File: rtl/s_box.sv
// AES forward S-box leaf cell: substitutes one byte per cycle via a constant 256-entry table.
// Latency 1 cycle (registered output); no backpressure, every in_valid byte is accepted.
module s_box (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  output logic [7:0] out_byte
);

  // Row = in_byte[7:4], column = in_byte[3:0] of the standard FIPS-197 table.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [7:0] sub_byte;

  always_comb begin
    sub_byte = SBOX[in_byte];
  end

  // out_byte only loads on valid input so idle cycles keep the last result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_byte <= sub_byte;
      end
    end
  end

endmodule

// File: tb/tb_s_box.sv
// Bench for s_box: GF(2^8)-based reference model with a per-cycle compare, plus literal vectors.
module tb_s_box;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       out_valid;
  logic [7:0] out_byte;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic       m_valid = 1'b0;
  logic [7:0] m_byte  = 8'h00;

  s_box dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .out_valid(out_valid),
    .out_byte (out_byte)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gf_mul(a, 8'(c)) == 8'h01) r = 8'(c);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] a);
    logic [7:0] b = gf_inv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  // Reference: registered behaviour of the block expressed directly from its rules.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_byte  = 8'h00;
    end else begin
      m_valid = in_valid;
      if (in_valid) m_byte = sbox_model(in_byte);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (out_valid !== m_valid || out_byte !== m_byte) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got v=%b b=%h want v=%b b=%h",
                 $time, out_valid, out_byte, m_valid, m_byte);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [7:0] b);
    @(negedge clk);
    rst = r; in_valid = v; in_byte = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input logic ev, input logic [7:0] eb);
    checks++;
    if (out_valid !== ev || out_byte !== eb) begin
      errors++;
      $display("FAIL %s got v=%b b=%h want v=%b b=%h", name, out_valid, out_byte, ev, eb);
    end
  endtask

  task automatic model_lit(input logic [7:0] a, input logic [7:0] e);
    logic [7:0] got = sbox_model(a);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL model_%h got %h want %h", a, got, e);
    end
  endtask

  logic [7:0] s1_in  [16] = '{8'he9, 8'hf8, 8'h48, 8'h08, 8'h9a, 8'hc6, 8'h8d, 8'h2a,
                              8'ha0, 8'hf4, 8'he2, 8'h2b, 8'h19, 8'h3d, 8'he3, 8'hbe};
  logic [7:0] s1_out [16] = '{8'h1e, 8'h41, 8'h52, 8'h30, 8'hb8, 8'hb4, 8'h5d, 8'he5,
                              8'he0, 8'hbf, 8'h98, 8'hf1, 8'hd4, 8'h27, 8'h11, 8'hae};
  logic [7:0] edge_in  [4] = '{8'h00, 8'h01, 8'hff, 8'h53};
  logic [7:0] edge_out [4] = '{8'h63, 8'h7c, 8'h16, 8'hed};

  int seen [256];
  int dups;

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_byte = 8'h53;

    for (int i = 0; i < 4; i++) model_lit(edge_in[i], edge_out[i]);
    model_lit(8'he9, 8'h1e);

    // Reset held two cycles with a valid byte present: it must be dropped.
    @(posedge clk); #1;
    chk_en = 1'b1;
    expect_lit("reset_c1", 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h53);
    expect_lit("reset_c2", 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h53);
    expect_lit("reset_idle", 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h53);
    expect_lit("first_after_reset", 1'b1, 8'hed);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, s1_in[i]);
      expect_lit($sformatf("stream_%0d", i), 1'b1, s1_out[i]);
    end

    // Edge codes separated by idle cycles: out_byte must hold through the gap.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, edge_in[i]);
      expect_lit($sformatf("edge_%h", edge_in[i]), 1'b1, edge_out[i]);
      step(1'b0, 1'b0, 8'haa);
      expect_lit($sformatf("gap_hold_%h", edge_in[i]), 1'b0, edge_out[i]);
    end

    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 8'(i));
      seen[out_byte]++;
    end
    dups = 0;
    for (int i = 0; i < 256; i++) if (seen[i] != 1) dups++;
    checks++;
    if (dups != 0) begin
      errors++;
      $display("FAIL permutation got %0d non-unique codes want 0", dups);
    end

    // One-cycle reset inside a valid burst.
    step(1'b0, 1'b1, 8'he9);
    expect_lit("burst_a", 1'b1, 8'h1e);
    step(1'b1, 1'b1, 8'hf8);
    expect_lit("mid_reset", 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h48);
    expect_lit("resume_a", 1'b1, 8'h52);
    step(1'b0, 1'b1, 8'h08);
    expect_lit("resume_b", 1'b1, 8'h30);
    step(1'b0, 1'b0, 8'h00);
    expect_lit("tail_idle", 1'b0, 8'h30);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
